// File: rtl/rv_pkg.sv
// Shared RV32 pipeline types and constants, plus the writeback-snoop helper
// used by the operand-fetch stage.
package rv_pkg;

  localparam int RV_XLEN  = 32;
  localparam int NUM_REGS = 32;

  typedef logic [4:0]         reg_index_t;
  typedef logic [RV_XLEN-1:0] word_t;

  localparam reg_index_t REG_ZERO = 5'd0;

  // True when the writeback port lands on architectural register r (never x0).
  function automatic logic wb_hit(input logic wb_en, input reg_index_t wb_idx,
                                  input reg_index_t r);
    return wb_en && (wb_idx == r) && (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-register scoreboard for x1..x31; x0 is hard-wired not-busy.
// A set on the same index as a clear in the same cycle wins.
module reg_scoreboard
  import rv_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_set_en,
  input  reg_index_t i_set_idx,
  input  logic       i_clr_en,
  input  reg_index_t i_clr_idx,
  input  logic       i_fclr_en,
  input  reg_index_t i_fclr_idx,
  input  reg_index_t i_q_rs1,
  input  reg_index_t i_q_rs2,
  input  reg_index_t i_q_rd,
  output logic       o_busy_rs1,
  output logic       o_busy_rs2,
  output logic       o_busy_rd
);

  logic [NUM_REGS-1:1] r_busy;
  logic [NUM_REGS-1:0] w_busy_all;

  assign w_busy_all = {r_busy, 1'b0};
  assign o_busy_rs1 = w_busy_all[i_q_rs1];
  assign o_busy_rs2 = w_busy_all[i_q_rs2];
  assign o_busy_rd  = w_busy_all[i_q_rd];

  // Per-register busy bit update: issue sets, writeback or flush clears.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= {(NUM_REGS-1){1'b0}};
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (i_set_en && (i_set_idx == reg_index_t'(i))) begin
          r_busy[i] <= 1'b1;
        end else if ((i_clr_en && (i_clr_idx == reg_index_t'(i))) ||
                     (i_fclr_en && (i_fclr_idx == reg_index_t'(i)))) begin
          r_busy[i] <= 1'b0;
        end else begin
          r_busy[i] <= r_busy[i];
        end
      end
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads the register file, forwards same-cycle writeback
// data, stalls on scoreboard hazards and presents operands to execute.
module operand_fetch
  import rv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int PAYLOAD_W = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [4:0]           i_rs1,
  input  logic [4:0]           i_rs2,
  input  logic [4:0]           i_rd,
  input  logic                 i_rd_en,
  input  logic [PAYLOAD_W-1:0] i_payload,
  output logic [4:0]           o_rf_index1,
  input  logic [XLEN-1:0]      i_rf_data1,
  output logic [4:0]           o_rf_index2,
  input  logic [XLEN-1:0]      i_rf_data2,
  input  logic                 i_wb_en,
  input  logic [4:0]           i_wb_index,
  input  logic [XLEN-1:0]      i_wb_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [XLEN-1:0]      o_op1,
  output logic [XLEN-1:0]      o_op2,
  output logic [4:0]           o_rd,
  output logic                 o_rd_en,
  output logic [PAYLOAD_W-1:0] o_payload,
  input  logic                 i_flush
);

  logic                 r_valid;
  logic [XLEN-1:0]      r_op1;
  logic [XLEN-1:0]      r_op2;
  reg_index_t           r_rd;
  logic                 r_rd_en;
  logic [PAYLOAD_W-1:0] r_payload;

  logic w_hit_rs1, w_hit_rs2, w_hit_rd;
  logic w_busy_rs1, w_busy_rs2, w_busy_rd;
  logic w_hazard, w_ready, w_accept;
  logic w_set_en, w_fclr_en;

  assign o_rf_index1 = i_rs1;
  assign o_rf_index2 = i_rs2;

  assign w_hit_rs1 = wb_hit(i_wb_en, i_wb_index, i_rs1);
  assign w_hit_rs2 = wb_hit(i_wb_en, i_wb_index, i_rs2);
  assign w_hit_rd  = wb_hit(i_wb_en, i_wb_index, i_rd);

  // A register retiring this cycle is no longer a hazard; its data is forwarded.
  assign w_hazard = (w_busy_rs1 && !w_hit_rs1) ||
                    (w_busy_rs2 && !w_hit_rs2) ||
                    (i_rd_en && w_busy_rd && !w_hit_rd);

  assign w_ready   = (!r_valid || i_ready) && !w_hazard && !i_flush;
  assign w_accept  = i_valid && w_ready;
  assign w_set_en  = w_accept && i_rd_en && (i_rd != REG_ZERO);
  assign w_fclr_en = i_flush && r_valid && r_rd_en;
  assign o_ready   = w_ready;

  reg_scoreboard u_scoreboard (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_set_en   (w_set_en),
    .i_set_idx  (i_rd),
    .i_clr_en   (i_wb_en),
    .i_clr_idx  (i_wb_index),
    .i_fclr_en  (w_fclr_en),
    .i_fclr_idx (r_rd),
    .i_q_rs1    (i_rs1),
    .i_q_rs2    (i_rs2),
    .i_q_rd     (i_rd),
    .o_busy_rs1 (w_busy_rs1),
    .o_busy_rs2 (w_busy_rs2),
    .o_busy_rd  (w_busy_rd)
  );

  // Output pipeline register towards execute.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid   <= 1'b0;
      r_op1     <= {XLEN{1'b0}};
      r_op2     <= {XLEN{1'b0}};
      r_rd      <= REG_ZERO;
      r_rd_en   <= 1'b0;
      r_payload <= {PAYLOAD_W{1'b0}};
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_op1     <= w_hit_rs1 ? i_wb_data : i_rf_data1;
      r_op2     <= w_hit_rs2 ? i_wb_data : i_rf_data2;
      r_rd      <= i_rd;
      r_rd_en   <= i_rd_en;
      r_payload <= i_payload;
    end else if (i_flush || i_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_valid   = r_valid;
  assign o_op1     = r_op1;
  assign o_op2     = r_op2;
  assign o_rd      = r_rd;
  assign o_rd_en   = r_rd_en;
  assign o_payload = r_payload;

endmodule

// File: tb/tb_operand_fetch.sv
// Table-driven bench for operand_fetch with an expected-result queue and a
// reference busy-register model.
module tb_operand_fetch;

  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic        rd_en;
    logic [31:0] rf1, rf2;
    logic        wb_en;
    logic [4:0]  wb_idx;
    logic [31:0] wb_data;
    logic        ready, flush;
    logic        exp_ready;
    logic [31:0] exp_op1, exp_op2;
  } vec_t;

  typedef struct {
    logic [31:0] op1, op2;
    logic [4:0]  rd;
    logic        rd_en;
    logic [31:0] payload;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, o_ready;
  logic [4:0]  i_rs1, i_rs2, i_rd;
  logic        i_rd_en;
  logic [31:0] i_payload;
  logic [4:0]  o_rf_index1, o_rf_index2;
  logic [31:0] i_rf_data1, i_rf_data2;
  logic        i_wb_en;
  logic [4:0]  i_wb_index;
  logic [31:0] i_wb_data;
  logic        o_valid, i_ready;
  logic [31:0] o_op1, o_op2;
  logic [4:0]  o_rd;
  logic        o_rd_en;
  logic [31:0] o_payload;
  logic        i_flush;

  int n_pass = 0;
  int n_total = 0;

  logic        m_valid;
  logic [31:0] m_busy;
  exp_t        q[$];
  vec_t        tbl[16];

  operand_fetch #(.XLEN(32), .PAYLOAD_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_rd_en(i_rd_en),
    .i_payload(i_payload), .o_rf_index1(o_rf_index1), .i_rf_data1(i_rf_data1),
    .o_rf_index2(o_rf_index2), .i_rf_data2(i_rf_data2), .i_wb_en(i_wb_en),
    .i_wb_index(i_wb_index), .i_wb_data(i_wb_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_op1(o_op1), .o_op2(o_op2), .o_rd(o_rd),
    .o_rd_en(o_rd_en), .o_payload(o_payload), .i_flush(i_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic rd_en,
                              input logic [31:0] rf1, input logic [31:0] rf2,
                              input logic wb_en, input logic [4:0] wb_idx,
                              input logic [31:0] wb_data, input logic rdy, input logic fl,
                              input logic exp_rdy, input logic [31:0] e1, input logic [31:0] e2);
    vec_t t;
    t.valid = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.rd_en = rd_en;
    t.rf1 = rf1; t.rf2 = rf2; t.wb_en = wb_en; t.wb_idx = wb_idx; t.wb_data = wb_data;
    t.ready = rdy; t.flush = fl; t.exp_ready = exp_rdy; t.exp_op1 = e1; t.exp_op2 = e2;
    return t;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, " o_valid"}, {63'd0, o_valid}, {63'd0, m_valid});
    chk({tag, " busy"}, {32'd0, dut.u_scoreboard.r_busy, 1'b0}, {32'd0, m_busy});
    if (m_valid && q.size() > 0) begin
      chk({tag, " op1"}, {32'd0, o_op1}, {32'd0, q[0].op1});
      chk({tag, " op2"}, {32'd0, o_op2}, {32'd0, q[0].op2});
      chk({tag, " rd/en"}, {58'd0, o_rd, o_rd_en}, {58'd0, q[0].rd, q[0].rd_en});
      chk({tag, " payload"}, {32'd0, o_payload}, {32'd0, q[0].payload});
    end
  endtask

  // Apply one vector from just after a rising edge, then check after the next edge.
  task automatic step(input vec_t v, input int idx);
    exp_t e;
    string tag;
    logic acc;
    tag = $sformatf("row%0d", idx);
    i_valid = v.valid; i_rs1 = v.rs1; i_rs2 = v.rs2; i_rd = v.rd; i_rd_en = v.rd_en;
    i_payload = 32'hC0DE_0000 + 32'(idx);
    i_rf_data1 = v.rf1; i_rf_data2 = v.rf2;
    i_wb_en = v.wb_en; i_wb_index = v.wb_idx; i_wb_data = v.wb_data;
    i_ready = v.ready; i_flush = v.flush;
    #2;
    chk({tag, " o_ready"}, {63'd0, o_ready}, {63'd0, v.exp_ready});
    chk({tag, " rf_index"}, {54'd0, o_rf_index1, o_rf_index2}, {54'd0, v.rs1, v.rs2});
    acc = v.valid && v.exp_ready;
    if (m_valid && (v.flush || v.ready)) begin
      if (v.flush && q.size() > 0 && q[0].rd_en) m_busy[q[0].rd] = 1'b0;
      if (q.size() > 0) void'(q.pop_front());
      m_valid = 1'b0;
    end
    if (v.wb_en) m_busy[v.wb_idx] = 1'b0;
    if (acc) begin
      e.op1 = v.exp_op1; e.op2 = v.exp_op2; e.rd = v.rd; e.rd_en = v.rd_en;
      e.payload = i_payload;
      q.push_back(e);
      m_valid = 1'b1;
      if (v.rd_en) m_busy[v.rd] = 1'b1;
    end
    m_busy[0] = 1'b0;
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  initial begin
    //             v  rs1 rs2 rd en rf1           rf2           wb wi  wdata         rdy fl er e1            e2
    tbl[0]  = mk(1, 1,  2,  3, 1, 32'h11,       32'h22,       0, 0,  32'h0,        1, 0, 1, 32'h11,       32'h22);
    tbl[1]  = mk(1, 3,  0,  4, 1, 32'h33,       32'h44,       0, 0,  32'h0,        1, 0, 0, 32'h0,        32'h0);
    tbl[2]  = mk(1, 3,  0,  4, 1, 32'h33,       32'h44,       0, 0,  32'h0,        1, 0, 0, 32'h0,        32'h0);
    tbl[3]  = mk(1, 3,  0,  4, 1, 32'h33,       32'h44,       1, 3,  32'hABCD,     1, 0, 1, 32'hABCD,     32'h44);
    tbl[4]  = mk(1, 0,  0,  0, 1, 32'hFFFF,     32'hFFFF,     0, 0,  32'h0,        1, 0, 1, 32'hFFFF,     32'hFFFF);
    tbl[5]  = mk(1, 5,  4,  6, 1, 32'h66,       32'h77,       1, 4,  32'h5555,     1, 0, 1, 32'h66,       32'h5555);
    tbl[6]  = mk(1, 9,  1,  0, 0, 32'h10,       32'h20,       1, 9,  32'h9999,     1, 0, 1, 32'h9999,     32'h20);
    tbl[7]  = mk(1, 1,  2,  6, 1, 32'h1,        32'h2,        0, 0,  32'h0,        1, 0, 0, 32'h0,        32'h0);
    tbl[8]  = mk(1, 2,  3,  6, 0, 32'hA,        32'hB,        0, 0,  32'h0,        1, 0, 1, 32'hA,        32'hB);
    tbl[9]  = mk(1, 1,  2,  5, 1, 32'h50,       32'h51,       0, 0,  32'h0,        0, 0, 0, 32'h0,        32'h0);
    tbl[10] = mk(1, 1,  2,  5, 1, 32'h50,       32'h51,       0, 0,  32'h0,        0, 0, 0, 32'h0,        32'h0);
    tbl[11] = mk(1, 1,  2,  5, 1, 32'h50,       32'h51,       0, 0,  32'h0,        0, 0, 0, 32'h0,        32'h0);
    tbl[12] = mk(1, 1,  2,  5, 1, 32'h50,       32'h51,       0, 0,  32'h0,        1, 0, 1, 32'h50,       32'h51);
    tbl[13] = mk(1, 1,  2,  8, 1, 32'h80,       32'h81,       0, 0,  32'h0,        0, 1, 0, 32'h0,        32'h0);
    tbl[14] = mk(1, 1,  2,  7, 1, 32'h70,       32'h71,       0, 0,  32'h0,        1, 0, 1, 32'h70,       32'h71);
    tbl[15] = mk(1, 2,  1,  7, 1, 32'h72,       32'h73,       1, 7,  32'h7777,     1, 0, 1, 32'h72,       32'h73);

    rst_n = 1'b0;
    i_valid = 1'b0; i_rs1 = 5'd0; i_rs2 = 5'd0; i_rd = 5'd0; i_rd_en = 1'b0;
    i_payload = 32'd0; i_rf_data1 = 32'd0; i_rf_data2 = 32'd0;
    i_wb_en = 1'b0; i_wb_index = 5'd0; i_wb_data = 32'd0;
    i_ready = 1'b1; i_flush = 1'b0;
    m_valid = 1'b0; m_busy = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_outputs("reset");
    chk("reset outputs", {o_op1, o_op2}, 64'd0);
    chk("reset rd/payload", {26'd0, o_rd, o_rd_en, o_payload}, 64'd0);
    chk("reset o_ready", {63'd0, o_ready}, 64'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) step(tbl[i], i);

    // Stall on busy x7, then asynchronous reset in the middle of the cycle.
    i_valid = 1'b1; i_rs1 = 5'd7; i_rs2 = 5'd0; i_rd = 5'd0; i_rd_en = 1'b0;
    i_wb_en = 1'b0; i_ready = 1'b0; i_flush = 1'b0;
    #2;
    chk("stall x7 o_ready", {63'd0, o_ready}, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("async rst o_valid", {63'd0, o_valid}, 64'd0);
    chk("async rst busy", {32'd0, dut.u_scoreboard.r_busy, 1'b0}, 64'd0);
    chk("async rst ops", {o_op1, o_op2}, 64'd0);
    i_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post rst o_valid", {63'd0, o_valid}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
